// File: rtl/lsu_mem_bridge.sv
// Load/store bridge: core memory port to a word-aligned valid/ready bus with byte strobes and load extension.
// Latency is 3 cycles minimum; the core is stalled through REQ/WAIT_RSP, and the request is held until bus_req_ready.
module lsu_mem_bridge #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ren,
   input  logic        cpu_wen,
   input  logic [2:0]  cpu_memop,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        cpu_err,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_addr,
   output logic        bus_wen,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_rsp_valid,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_q;
   logic [1:0]       off_q;
   logic             access, fault, timeout;
   logic [31:0]      st_wdata, ld_data, sh;
   logic [3:0]       st_wstrb;

   assign access  = cpu_ren | cpu_wen;
   assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      fault = 1'b0;
      case (cpu_memop)
         3'b000:  fault = 1'b0;
         3'b001:  fault = cpu_addr[0];
         3'b010:  fault = |cpu_addr[1:0];
         3'b100:  fault = cpu_wen;
         3'b101:  fault = cpu_wen | cpu_addr[0];
         default: fault = 1'b1;
      endcase
   end

   always_comb begin
      st_wdata = cpu_wdata;
      st_wstrb = 4'b1111;
      case (cpu_memop[1:0])
         2'b00: begin
            st_wdata = {4{cpu_wdata[7:0]}};
            st_wstrb = 4'b0001 << cpu_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{cpu_wdata[15:0]}};
            st_wstrb = 4'b0011 << cpu_addr[1:0];
         end
         default: begin
            st_wdata = cpu_wdata;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   // Extraction uses the memop/offset latched at issue, not the live core inputs.
   always_comb begin
      sh      = bus_rdata >> {off_q, 3'b000};
      ld_data = bus_rdata;
      case (op_q)
         3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
         3'b100:  ld_data = {24'b0, sh[7:0]};
         3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
         3'b101:  ld_data = {16'b0, sh[15:0]};
         default: ld_data = bus_rdata;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      bus_req_valid = 1'b0;
      cpu_stall     = 1'b0;
      case (state)
         IDLE: begin
            cpu_stall = access & ~fault;
            if (access && !fault) state_nxt = REQ;
         end
         REQ: begin
            bus_req_valid = 1'b1;
            cpu_stall     = 1'b1;
            if (bus_req_ready) state_nxt = WAIT_RSP;
         end
         WAIT_RSP: begin
            cpu_stall = 1'b1;
            if (bus_rsp_valid || timeout) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         op_q      <= 3'b0;
         off_q     <= 2'b0;
         bus_addr  <= 32'b0;
         bus_wen   <= 1'b0;
         bus_wdata <= 32'b0;
         bus_wstrb <= 4'b0;
         cpu_rdata <= 32'b0;
         cpu_err   <= 1'b0;
      end else begin
         cpu_err <= 1'b0;
         case (state)
            IDLE: begin
               if (access && fault) begin
                  cpu_err   <= 1'b1;
                  cpu_rdata <= 32'b0;
               end else if (access) begin
                  bus_addr  <= {cpu_addr[31:2], 2'b00};
                  bus_wen   <= cpu_wen;
                  bus_wdata <= st_wdata;
                  bus_wstrb <= cpu_wen ? st_wstrb : 4'b0000;
                  op_q      <= cpu_memop;
                  off_q     <= cpu_addr[1:0];
               end
            end
            WAIT_RSP: begin
               cnt <= cnt + 1'b1;
               if (bus_rsp_valid) begin
                  if (!bus_wen) cpu_rdata <= ld_data;
               end else if (timeout) begin
                  cpu_err   <= 1'b1;
                  cpu_rdata <= 32'b0;
               end
            end
            DONE:    cnt <= '0;
            default: ;
         endcase
      end
   end

endmodule
